// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage hazard detection, pipeline enable/flush control,
// mult/div occupancy sequencer and saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_is_branch,
    input  logic             id_branch_tkn,
    input  logic             id_md_start,
    input  logic             id_md_is_div,
    input  logic             id_use_hilo,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_rd,
    input  logic             mem_memread,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             md_busy,
    output logic             md_hilo_we,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // Counter is loaded with LAT-1 on acceptance, so DONE lands LAT cycles later.
    localparam logic [5:0]       MUL_CNT = 6'(MUL_LAT - 1);
    localparam logic [5:0]       DIV_CNT = 6'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    md_state_t  md_state_r;
    md_state_t  md_state_s;
    logic [5:0] md_cnt_r;
    logic [5:0] md_cnt_s;
    logic       lu_s;
    logic       br1_s;
    logic       br2_s;
    logic       md_s;
    logic       stall_s;
    logic [CNT_W-1:0] stall_cnt_r;

    // A producer register matches a source only when that source is read and
    // the producer is not $zero (writes to $zero are discarded).
    function automatic logic reg_hit(input logic [4:0] rd, input logic [4:0] src,
                                     input logic use_src);
        return use_src && (rd != 5'd0) && (rd == src);
    endfunction

    // Hazard terms: load-use, branch-vs-EX result, branch-vs-MEM load, HI/LO busy.
    always_comb begin
        lu_s    = ex_memread && (reg_hit(ex_rd, id_rs, id_use_rs) ||
                                 reg_hit(ex_rd, id_rt, id_use_rt));
        br1_s   = id_is_branch && ex_regwrite && (reg_hit(ex_rd, id_rs, 1'b1) ||
                                                  reg_hit(ex_rd, id_rt, 1'b1));
        br2_s   = id_is_branch && mem_memread && (reg_hit(mem_rd, id_rs, 1'b1) ||
                                                  reg_hit(mem_rd, id_rt, 1'b1));
        md_s    = md_busy && (id_use_hilo || id_md_start);
        stall_s = lu_s || br1_s || br2_s || md_s;
    end

    // Mult/div sequencer next-state: a start is accepted only in IDLE when the
    // ID instruction is not itself stalled by another hazard.
    always_comb begin
        md_state_s = md_state_r;
        md_cnt_s   = md_cnt_r;
        case (md_state_r)
            MD_IDLE: begin
                if (id_md_start && !stall_s) begin
                    md_state_s = MD_BUSY;
                    md_cnt_s   = id_md_is_div ? DIV_CNT : MUL_CNT;
                end else begin
                    md_state_s = MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (md_cnt_r == 6'd1) begin
                    md_state_s = MD_DONE;
                    md_cnt_s   = 6'd0;
                end else begin
                    md_cnt_s   = md_cnt_r - 6'd1;
                end
            end
            MD_DONE: begin
                md_state_s = MD_IDLE;
            end
            default: begin
                md_state_s = MD_IDLE;
                md_cnt_s   = 6'd0;
            end
        endcase
    end

    // Mult/div state and latency counter; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_state_r <= MD_IDLE;
            md_cnt_r   <= 6'd0;
        end else begin
            md_state_r <= md_state_s;
            md_cnt_r   <= md_cnt_s;
        end
    end

    // Pipeline enables and flushes; a taken branch is ignored while stalled.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        md_hilo_we = 1'b0;
        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            md_hilo_we = 1'b0;
        end else if (stall_s) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b1;
            md_hilo_we = (md_state_r == MD_DONE);
        end else begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = id_is_branch && id_branch_tkn;
            idex_flush = 1'b0;
            md_hilo_we = (md_state_r == MD_DONE);
        end
    end

    assign md_busy = (md_state_r != MD_IDLE);

    // Saturating count of stalled cycles for performance debug.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: table of single-cycle hazard
// vectors followed by hand-written mult/div and reset sequences.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
    logic        id_use_rs, id_use_rt, id_is_branch, id_branch_tkn;
    logic        id_md_start, id_md_is_div, id_use_hilo;
    logic        ex_regwrite, ex_memread, mem_memread;
    logic        pc_en, ifid_en, ifid_flush, idex_flush, md_busy, md_hilo_we;
    logic [31:0] stall_cnt;

    int passed = 0;
    int total  = 0;
    int exp_cnt = 0;

    hazard_stall_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_is_branch(id_is_branch), .id_branch_tkn(id_branch_tkn),
        .id_md_start(id_md_start), .id_md_is_div(id_md_is_div), .id_use_hilo(id_use_hilo),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_memread(mem_memread),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .md_busy(md_busy), .md_hilo_we(md_hilo_we), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       is_br;
        logic       br_tkn;
        logic       md_start;
        logic       use_hilo;
        logic [4:0] ex_rd;
        logic       ex_rw;
        logic       ex_mr;
        logic [4:0] mem_rd;
        logic       mem_mr;
        logic       exp_stall;
        logic       exp_iflush;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_is_branch = 1'b0; id_branch_tkn = 1'b0;
        id_md_start = 1'b0; id_md_is_div = 1'b0; id_use_hilo = 1'b0;
        ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = 5'd0; mem_memread = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles until the md_hilo_we pulse; 0 means none within the bound.
    task automatic wait_pulse(output int p);
        bit done;
        p = 0;
        done = 1'b0;
        for (int i = 1; i <= 40 && !done; i++) begin
            @(negedge clk);
            if (md_hilo_we) begin
                p = i;
                done = 1'b1;
            end
            next_cycle();
        end
    endtask

    initial begin
        int p;
        int pulses;

        //           rs     rt  urs  urt  br   tkn  mds  hilo  exrd ewr  emr  memrd mmr  stall iflush
        vecs[0]  = '{5'd8,  5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 5'd8, 1'b1,1'b1, 5'd0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{5'd0,  5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 5'd0, 1'b1,1'b1, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{5'd1,  5'd9, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 5'd9, 1'b1,1'b1, 5'd0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{5'd1,  5'd9, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 5'd9, 1'b1,1'b1, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{5'd2,  5'd5, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b0, 5'd5, 1'b1,1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{5'd2,  5'd5, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b0, 5'd5, 1'b0,1'b0, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{5'd3,  5'd4, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 5'd0, 1'b0,1'b0, 5'd3, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{5'd0,  5'd4, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b0, 5'd0, 1'b0,1'b0, 5'd0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{5'd3,  5'd4, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 5'd0, 1'b0,1'b0, 5'd3, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{5'd0,  5'd7, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 5'd0, 1'b1,1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{5'd6,  5'd6, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0, 5'd6, 1'b1,1'b1, 5'd0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{5'd10, 5'd11,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 5'd12,1'b1,1'b0, 5'd13,1'b1, 1'b0, 1'b0};
        vecs[12] = '{5'd0,  5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 5'd0, 1'b0,1'b0, 5'd0, 1'b0, 1'b0, 1'b0};

        // Reset held with a load-use hazard present: nothing may be counted.
        idle_inputs();
        ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
        rst = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_ifid_en", 32'(ifid_en), 32'd0);
        chk("rst_ifid_flush", 32'(ifid_flush), 32'd1);
        chk("rst_idex_flush", 32'(idex_flush), 32'd1);
        chk("rst_hilo_we", 32'(md_hilo_we), 32'd0);
        chk("rst_md_busy", 32'(md_busy), 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        next_cycle();
        rst = 1'b0;
        idle_inputs();

        // Single-cycle hazard vectors.
        for (int v = 0; v < 13; v++) begin
            id_rs = vecs[v].rs; id_rt = vecs[v].rt;
            id_use_rs = vecs[v].use_rs; id_use_rt = vecs[v].use_rt;
            id_is_branch = vecs[v].is_br; id_branch_tkn = vecs[v].br_tkn;
            id_md_start = vecs[v].md_start; id_md_is_div = 1'b0;
            id_use_hilo = vecs[v].use_hilo;
            ex_rd = vecs[v].ex_rd; ex_regwrite = vecs[v].ex_rw; ex_memread = vecs[v].ex_mr;
            mem_rd = vecs[v].mem_rd; mem_memread = vecs[v].mem_mr;
            @(negedge clk);
            chk($sformatf("v%0d_pc_en", v), 32'(pc_en), 32'(!vecs[v].exp_stall));
            chk($sformatf("v%0d_ifid_en", v), 32'(ifid_en), 32'(!vecs[v].exp_stall));
            chk($sformatf("v%0d_idex_flush", v), 32'(idex_flush), 32'(vecs[v].exp_stall));
            chk($sformatf("v%0d_ifid_flush", v), 32'(ifid_flush), 32'(vecs[v].exp_iflush));
            chk($sformatf("v%0d_md_busy", v), 32'(md_busy), 32'd0);
            chk($sformatf("v%0d_stall_cnt", v), stall_cnt, 32'(exp_cnt));
            if (vecs[v].exp_stall) exp_cnt++;
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        chk("tbl_stall_cnt", stall_cnt, 32'(exp_cnt));
        next_cycle();

        // Mult accepted, then mfhi stalls until the unit returns to IDLE.
        id_md_start = 1'b1; id_md_is_div = 1'b0;
        @(negedge clk);
        chk("mul_accept_pc_en", 32'(pc_en), 32'd1);
        next_cycle();
        id_md_start = 1'b0; id_use_hilo = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("mul_c%0d_busy", k), 32'(md_busy), 32'd1);
            chk($sformatf("mul_c%0d_hilo_we", k), 32'(md_hilo_we), 32'(k == 4));
            chk($sformatf("mul_c%0d_pc_en", k), 32'(pc_en), 32'd0);
            next_cycle();
        end
        exp_cnt += 4;
        @(negedge clk);
        chk("mul_end_busy", 32'(md_busy), 32'd0);
        chk("mul_end_pc_en", 32'(pc_en), 32'd1);
        chk("mul_end_stall_cnt", stall_cnt, 32'(exp_cnt));
        next_cycle();
        idle_inputs();

        // Back-to-back divs: the second is held off until the first completes.
        id_md_start = 1'b1; id_md_is_div = 1'b1;
        @(negedge clk);
        chk("div1_accept_pc_en", 32'(pc_en), 32'd1);
        next_cycle();
        wait_pulse(p);
        chk("div1_latency", 32'(p), 32'd32);
        exp_cnt += 32;
        @(negedge clk);
        chk("div2_accept_pc_en", 32'(pc_en), 32'd1);
        chk("div2_accept_busy", 32'(md_busy), 32'd0);
        chk("div2_accept_stall_cnt", stall_cnt, 32'(exp_cnt));
        next_cycle();
        idle_inputs();
        wait_pulse(p);
        chk("div2_latency", 32'(p), 32'd32);
        @(negedge clk);
        chk("div2_end_busy", 32'(md_busy), 32'd0);
        chk("div2_stall_cnt", stall_cnt, 32'(exp_cnt));
        next_cycle();

        // Reset while a div is BUSY with cnt=10 aborts it without a HI/LO write.
        id_md_start = 1'b1; id_md_is_div = 1'b1;
        next_cycle();
        id_md_start = 1'b0;
        for (int k = 1; k <= 21; k++) next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_busy", 32'(md_busy), 32'd1);
        chk("abort_rst_hilo_we", 32'(md_hilo_we), 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(md_busy), 32'd0);
        chk("abort_stall_cnt", stall_cnt, 32'd0);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (md_hilo_we) pulses++;
            next_cycle();
        end
        chk("abort_no_pulse", 32'(pulses), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
